// File: rtl/multi_byte_add_seq_pkg.sv
// Shared constants and state encoding for the byte-serial wide adder sequencer.
package multi_byte_add_seq_pkg;

  localparam int BYTE_W = 8;

  // Encoding 2'd3 is unused; the next-state logic steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multi_byte_add_seq_adder.sv
// Team 8-bit combinational ripple adder; a sibling of the sequencer, wired to its add_* ports.
module multi_byte_add_seq_adder
  import multi_byte_add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[BYTE_W];
  end

endmodule

// File: rtl/multi_byte_add_seq.sv
// Sequences an NBYTES-wide add through an external 8-bit adder, one byte per clock,
// least-significant byte first, with a start/busy/done handshake.
module multi_byte_add_seq
  import multi_byte_add_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
)
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a_in,
  input  logic [BYTE_W*NBYTES-1:0] b_in,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum_out,
  output logic                     cout_out,
  output logic [BYTE_W-1:0]        add_a,
  output logic [BYTE_W-1:0]        add_b,
  output logic                     add_cin,
  input  logic [BYTE_W-1:0]        add_s,
  input  logic                     add_cout
);

  localparam int unsigned W     = BYTE_W * NBYTES;
  localparam int unsigned IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             cin_reg;
  logic             carry_reg;
  logic [W-1:0]     partial;
  logic [W-1:0]     partial_next;
  logic             last_byte;
  logic             accept;

  assign last_byte = (idx == LAST_IDX);
  assign accept    = start && (state != RUN);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        state_next = start ? RUN : IDLE;
      end
      RUN: begin
        busy       = 1'b1;
        state_next = last_byte ? DONE : RUN;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Final sum must include the byte the adder is presenting on the last edge.
  always_comb begin
    partial_next = partial;
    partial_next[BYTE_W*idx +: BYTE_W] = add_s;
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[BYTE_W*idx +: BYTE_W];
      add_b   = b_reg[BYTE_W*idx +: BYTE_W];
      add_cin = (idx == '0) ? cin_reg : carry_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      partial   <= '0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
    end else if (state == RUN) begin
      partial   <= partial_next;
      carry_reg <= add_cout;
      if (last_byte) begin
        idx      <= '0;
        sum_out  <= partial_next;
        cout_out <= add_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end else if (accept) begin
      a_reg   <= a_in;
      b_reg   <= b_in;
      cin_reg <= cin;
      idx     <= '0;
    end
  end

endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Scoreboard bench: sequencer plus sibling 8-bit adder, directed vectors with fixed expectations.
module tb_multi_byte_add_seq;

  localparam int NB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in  = '0;
  logic [31:0] b_in  = '0;
  logic        cin   = 1'b0;
  logic        busy, done, cout_out, add_cin, add_cout;
  logic [31:0] sum_out;
  logic [7:0]  add_a, add_b, add_s;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  multi_byte_add_seq #(.NBYTES(NB)) u_dut (
    .clock(clock), .reset(reset), .start(start),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  multi_byte_add_seq_adder u_add (
    .a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_cout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum_out", 64'(sum_out), 64'(e.sum));
        chk("cout_out", 64'(cout_out), 64'(e.cout));
        chk("done_latency", 64'(cyc - e.cyc), 64'(NB));
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
  endtask

  task automatic accept(input logic [31:0] s, input logic co, input bit push);
    exp_t e;
    @(posedge clock);
    #1;
    if (push) begin
      e.sum  = s;
      e.cout = co;
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [31:0] s, input logic co, input bit push);
    @(negedge clock);
    drive(a, b, c);
    accept(s, co, push);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_cout", 64'(cout_out), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Carry from byte 0 into byte 1.
    issue(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done();

    // Every RUN cycle presents 0x77/0x77; previous result must hold meanwhile.
    issue(32'h77777777, 32'h77777777, 1'b0, 32'hEEEEEEEE, 1'b0, 1'b1);
    for (int i = 0; i < NB; i++) begin
      @(negedge clock);
      chk("t3_add_a", 64'(add_a), 64'h77);
      chk("t3_add_b", 64'(add_b), 64'h77);
      chk("t3_hold_sum", 64'(sum_out), 64'h100);
    end
    wait_done();

    // Full ripple driven by cin.
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1);
    @(negedge clock);
    chk("t2_add_cin0", 64'(add_cin), 64'd1);
    wait_done();

    // Start pulsed while busy is ignored.
    issue(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b1);
    @(negedge clock);
    drive(32'hAAAAAAAA, 32'h44444444, 1'b1);
    @(negedge clock);
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clock);
    chk("t4_idle", 64'(busy), 64'd0);

    // Back-to-back: start held through the DONE cycle.
    issue(32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1'b1);
    wait_done();
    drive(32'hAAAAAAAA, 32'h44444444, 1'b1);
    accept(32'hEEEEEEEF, 1'b0, 1'b1);
    chk("t5_no_gap_busy", 64'(busy), 64'd1);
    wait_done();

    // Reset during RUN at idx=2 aborts the add.
    issue(32'h11223344, 32'h55667788, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk("t6_idx2_add_a", 64'(add_a), 64'h22);
    chk("t6_idx2_add_b", 64'(add_b), 64'h66);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_sum", 64'(sum_out), 64'd0);
    chk("t6_cout", 64'(cout_out), 64'd0);
    chk("t6_add_a", 64'(add_a), 64'd0);
    chk("t6_add_b", 64'(add_b), 64'd0);
    chk("t6_add_cin", 64'(add_cin), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    issue(32'h89ABCDEF, 32'h76543210, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_done();

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
